// File: rtl/pixel_xform_ctrl.sv
// Word-at-a-time DMA sequencer: reads a source word, passes it through the transform
// unit over a req/ack handshake, and writes the result to the destination buffer.
module pixel_xform_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int MAX_WORDS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              slave_waitrequest,
    input  logic [2:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    output logic              xf_req,
    output logic [31:0]       xf_data,
    input  logic              xf_ack,
    input  logic [31:0]       xf_result
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_XF      = 3'd3;
    localparam logic [2:0] S_WR      = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]             state;
    logic [ADDR_W-1:0]      csr_dst;
    logic [ADDR_W-1:0]      csr_src;
    logic [MAX_WORDS_W-1:0] csr_count;
    logic [ADDR_W-1:0]      src_ptr;
    logic [ADDR_W-1:0]      dst_ptr;
    logic [MAX_WORDS_W-1:0] count_q;
    logic [MAX_WORDS_W-1:0] processed;
    logic [MAX_WORDS_W-1:0] proc_next;
    logic [31:0]            data_q;
    logic [31:0]            result_q;
    logic                   start_taken;
    logic                   idle;
    logic                   launch;
    logic                   csr_wr;

    // Slave write data is wider than the count register; the upper bits are don't-care.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, slave_writedata};

    assign idle      = (state == S_IDLE);
    assign proc_next = processed + 1'b1;

    // A start write that already launched a job stays stalled until the job returns to
    // IDLE; start_taken lets that same held access complete there without relaunching.
    assign launch = !rst && idle && slave_write && (slave_address == 3'd0) && !start_taken;
    assign csr_wr = idle && slave_write && (slave_address != 3'd0) && (slave_address <= 3'd3);

    assign slave_waitrequest = !rst && (slave_read || slave_write) && (!idle || launch);

    always_comb begin
        slave_readdata = 32'd0;
        if (!rst && idle && slave_read) begin
            case (slave_address)
                3'd0:    slave_readdata = 32'(processed);
                3'd1:    slave_readdata = 32'(csr_dst);
                3'd2:    slave_readdata = 32'(csr_src);
                3'd3:    slave_readdata = 32'(csr_count);
                3'd4:    slave_readdata = result_q;
                default: slave_readdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        master_read      = (state == S_RD_REQ);
        master_write     = (state == S_WR);
        xf_req           = (state == S_XF);
        master_address   = '0;
        master_writedata = 32'd0;
        xf_data          = 32'd0;
        if (state == S_RD_REQ) begin
            master_address = src_ptr;
        end
        if (state == S_WR) begin
            master_address   = dst_ptr;
            master_writedata = result_q;
        end
        if (state == S_XF) begin
            xf_data = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            csr_dst     <= '0;
            csr_src     <= '0;
            csr_count   <= '0;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            count_q     <= '0;
            processed   <= '0;
            data_q      <= 32'd0;
            result_q    <= 32'd0;
            start_taken <= 1'b0;
        end else begin
            if (launch) begin
                start_taken <= 1'b1;
            end else if (idle) begin
                start_taken <= 1'b0;
            end

            if (csr_wr) begin
                case (slave_address)
                    3'd1:    csr_dst   <= ADDR_W'(slave_writedata);
                    3'd2:    csr_src   <= ADDR_W'(slave_writedata);
                    default: csr_count <= slave_writedata[MAX_WORDS_W-1:0];
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        src_ptr   <= csr_src;
                        dst_ptr   <= csr_dst;
                        count_q   <= csr_count;
                        processed <= '0;
                        state     <= (csr_count == '0) ? S_DONE : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!master_waitrequest) begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        data_q <= master_readdata;
                        state  <= S_XF;
                    end
                end
                S_XF: begin
                    if (xf_ack) begin
                        result_q <= xf_result;
                        state    <= S_WR;
                    end
                end
                S_WR: begin
                    if (!master_waitrequest) begin
                        src_ptr   <= src_ptr + ADDR_W'(4);
                        dst_ptr   <= dst_ptr + ADDR_W'(4);
                        processed <= proc_next;
                        state     <= (proc_next < count_q) ? S_RD_REQ : S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_xform_ctrl.sv
// Bench for pixel_xform_ctrl: memory/transform responder on the master side, CSR driver
// tasks on the slave side, and address/data queues for the expected bus traffic.
module tb_pixel_xform_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        slave_waitrequest;
    logic [2:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        xf_req;
    logic [31:0] xf_data;
    logic        xf_ack;
    logic [31:0] xf_result;

    pixel_xform_ctrl #(.ADDR_W(32), .MAX_WORDS_W(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_readdata       (slave_readdata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .xf_req               (xf_req),
        .xf_data              (xf_data),
        .xf_ack               (xf_ack),
        .xf_result            (xf_result)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h11223344 ^ ((a - 32'h100) * 32'h00404041);
    endfunction

    task automatic push_job(input logic [31:0] src, input logic [31:0] dst, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            rd_q.push_back(src + 32'(4 * i));
            wa_q.push_back(dst + 32'(4 * i));
            wd_q.push_back(~mem_word(src + 32'(4 * i)));
        end
    endtask

    // ---------------- master-side responder / monitor ----------------
    bit          bp = 1'b0;
    bit          hold_wr = 1'b0;
    bit          noise = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_xf = 0;

    initial begin
        logic        pend;
        int          pend_cnt;
        logic [31:0] pend_data;
        bit          xf_busy;
        int          xf_cnt;
        logic        prev_rd_stall, prev_wr_stall, prev_xf_stall;
        logic [31:0] prev_addr, prev_data, prev_xfd;
        logic [31:0] exp_a, exp_d;
        pend = 1'b0; pend_cnt = 0; pend_data = 32'd0; xf_busy = 1'b0; xf_cnt = 0;
        prev_rd_stall = 1'b0; prev_wr_stall = 1'b0; prev_xf_stall = 1'b0;
        prev_addr = 32'd0; prev_data = 32'd0; prev_xfd = 32'd0;
        master_waitrequest = 1'b0; master_readdata = 32'd0; master_readdatavalid = 1'b0;
        xf_ack = 1'b0; xf_result = 32'd0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            master_readdata      = 32'd0;
            xf_ack               = 1'b0;
            xf_result            = 32'd0;
            if (noise || rst) begin
                if (noise) begin
                    master_waitrequest   = 1'($urandom_range(0, 1));
                    master_readdatavalid = 1'($urandom_range(0, 1));
                    master_readdata      = $urandom;
                    xf_ack               = 1'($urandom_range(0, 1));
                    xf_result            = $urandom;
                end else begin
                    master_waitrequest = hold_wr;
                end
                pend = 1'b0; xf_busy = 1'b0;
                prev_rd_stall = 1'b0; prev_wr_stall = 1'b0; prev_xf_stall = 1'b0;
                continue;
            end
            if (prev_rd_stall) begin
                check_val("rd_hold", 32'(master_read), 32'd1);
                check_val("rd_addr_hold", master_address, prev_addr);
            end
            if (prev_wr_stall) begin
                check_val("wr_hold", 32'(master_write), 32'd1);
                check_val("wr_addr_hold", master_address, prev_addr);
                check_val("wr_data_hold", master_writedata, prev_data);
            end
            if (prev_xf_stall) begin
                check_val("xf_req_hold", 32'(xf_req), 32'd1);
                check_val("xf_data_hold", xf_data, prev_xfd);
            end
            check_val("rd_wr_exclusive", 32'(master_read & master_write), 32'd0);

            if (pend) begin
                if (pend_cnt == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = pend_data;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end

            if (hold_wr && master_write) master_waitrequest = 1'b1;
            else if (bp)                 master_waitrequest = 1'($urandom_range(0, 1));
            else                         master_waitrequest = 1'b0;

            if (master_read && !master_waitrequest) begin
                n_rd++;
                exp_a = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxxxxxx;
                check_val("rd_addr", master_address, exp_a);
                pend      = 1'b1;
                pend_cnt  = bp ? $urandom_range(0, 5) : 0;
                pend_data = mem_word(master_address);
            end
            if (master_write && !master_waitrequest) begin
                n_wr++;
                exp_a = (wa_q.size() > 0) ? wa_q.pop_front() : 32'hxxxxxxxx;
                exp_d = (wd_q.size() > 0) ? wd_q.pop_front() : 32'hxxxxxxxx;
                check_val("wr_addr", master_address, exp_a);
                check_val("wr_data", master_writedata, exp_d);
            end

            if (xf_req) begin
                if (!xf_busy) begin
                    xf_busy = 1'b1;
                    xf_cnt  = bp ? $urandom_range(0, 7) : 0;
                end
                if (xf_cnt == 0) begin
                    xf_ack    = 1'b1;
                    xf_result = ~xf_data;
                    xf_busy   = 1'b0;
                    n_xf++;
                end else begin
                    xf_cnt--;
                end
            end else if (bp && $urandom_range(0, 7) == 0) begin
                xf_ack    = 1'b1;
                xf_result = 32'hDEADBEEF;
            end

            prev_rd_stall = master_read && master_waitrequest;
            prev_wr_stall = master_write && master_waitrequest;
            prev_xf_stall = xf_req && !xf_ack;
            prev_addr     = master_address;
            prev_data     = master_writedata;
            prev_xfd      = xf_data;
        end
    end

    // ---------------- CSR driver tasks ----------------
    task automatic csr_write(input logic [2:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        forever begin
            #1;
            if (!slave_waitrequest) break;
            waits++;
            if (waits > 5000) begin
                check_val("csr_wr_timeout", 32'(waits), 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 slave_write = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        d = 32'd0;
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        forever begin
            #1;
            if (!slave_waitrequest) begin
                d = slave_readdata;
                break;
            end
            waits++;
            if (waits > 5000) begin
                check_val("csr_rd_timeout", 32'(waits), 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 slave_read = 1'b0;
    endtask

    // Start pulse held for one edge only, leaving the slave port free for a busy access.
    task automatic start_pulse();
        @(negedge clk);
        slave_address = 3'd0; slave_writedata = 32'd0; slave_write = 1'b1;
        @(posedge clk);
        #1 slave_write = 1'b0;
    endtask

    task automatic setup_job(input logic [31:0] src, input logic [31:0] dst, input int cnt);
        int w;
        csr_write(3'd2, src, w);
        check_val("cfg_src_nowait", 32'(w), 32'd0);
        csr_write(3'd1, dst, w);
        csr_write(3'd3, 32'(cnt), w);
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int cnt);
        int w;
        logic [31:0] v;
        setup_job(src, dst, cnt);
        push_job(src, dst, cnt);
        csr_write(3'd0, 32'd0, w);
        check_val("job_rd_q_empty", 32'(rd_q.size()), 32'd0);
        check_val("job_wr_q_empty", 32'(wa_q.size()), 32'd0);
        csr_read(3'd0, v, w);
        check_val("job_status", v, 32'(cnt));
        csr_read(3'd4, v, w);
        check_val("job_last_result", v, ~mem_word(src + 32'(4 * (cnt - 1))));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          w;
        int          r0, w0, x0;
        int          guard;
        logic [31:0] v;
        logic [31:0] rsrc;
        rst = 1'b1; noise = 1'b1;
        slave_address = 3'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'd0;

        // Reset with toggling strobes
        repeat (3) begin
            @(negedge clk);
            slave_read      = 1'($urandom_range(0, 1));
            slave_write     = 1'($urandom_range(0, 1));
            slave_address   = 3'($urandom_range(0, 7));
            slave_writedata = $urandom;
            #1;
            check_val("rst_master_read", 32'(master_read), 32'd0);
            check_val("rst_master_write", 32'(master_write), 32'd0);
            check_val("rst_master_addr", master_address, 32'd0);
            check_val("rst_master_wdata", master_writedata, 32'd0);
            check_val("rst_xf_req", 32'(xf_req), 32'd0);
            check_val("rst_xf_data", xf_data, 32'd0);
            check_val("rst_slave_wait", 32'(slave_waitrequest), 32'd0);
            check_val("rst_slave_rdata", slave_readdata, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; noise = 1'b0;
        slave_read = 1'b0; slave_write = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            csr_read(3'(i), v, w);
            check_val("rst_csr", v, 32'd0);
            check_val("rst_csr_nowait", 32'(w), 32'd0);
        end

        // Basic zero-wait job: exact stall length 1 + 4*4 + 1
        setup_job(32'h100, 32'h200, 4);
        push_job(32'h100, 32'h200, 4);
        r0 = n_rd; w0 = n_wr; x0 = n_xf;
        csr_write(3'd0, 32'd0, w);
        check_val("basic_stall_cycles", 32'(w), 32'd18);
        check_val("basic_reads", 32'(n_rd - r0), 32'd4);
        check_val("basic_writes", 32'(n_wr - w0), 32'd4);
        check_val("basic_xf", 32'(n_xf - x0), 32'd4);
        check_val("basic_rd_q_empty", 32'(rd_q.size()), 32'd0);
        csr_read(3'd0, v, w);
        check_val("basic_status", v, 32'd4);
        csr_read(3'd4, v, w);
        check_val("basic_last_result", v, ~mem_word(32'h10C));
        csr_read(3'd2, v, w);
        check_val("basic_src_readback", v, 32'h100);
        csr_read(3'd5, v, w);
        check_val("offset5_zero", v, 32'd0);

        // COUNT = 0
        csr_write(3'd3, 32'd0, w);
        r0 = n_rd; w0 = n_wr; x0 = n_xf;
        csr_write(3'd0, 32'd0, w);
        check_val("cnt0_within_3", 32'(w <= 3), 32'd1);
        csr_read(3'd0, v, w);
        check_val("cnt0_status", v, 32'd0);
        check_val("cnt0_no_reads", 32'(n_rd - r0), 32'd0);
        check_val("cnt0_no_writes", 32'(n_wr - w0), 32'd0);
        check_val("cnt0_no_xf", 32'(n_xf - x0), 32'd0);

        // Backpressure, including address wrap and a single-word job
        bp = 1'b1;
        run_job(32'hFFFF_FFF8, 32'h1000, 6);
        run_job(32'h40, 32'hFFFF_FFFC, 1);
        for (int j = 0; j < 3; j++) begin
            rsrc = {$urandom_range(0, 255), 2'b00} + 32'h2000;
            run_job(rsrc, rsrc + 32'h8000, $urandom_range(1, 7));
        end
        bp = 1'b0;

        // Busy access: DST write mid-job stalls, job keeps old DST
        setup_job(32'h500, 32'h600, 3);
        push_job(32'h500, 32'h600, 3);
        start_pulse();
        csr_write(3'd1, 32'h700, w);
        check_val("busy_stalled", 32'(w > 0), 32'd1);
        check_val("busy_wr_q_empty", 32'(wa_q.size()), 32'd0);
        csr_read(3'd1, v, w);
        check_val("busy_new_dst", v, 32'h700);
        csr_read(3'd0, v, w);
        check_val("busy_status", v, 32'd3);

        // Reset during a stalled write
        hold_wr = 1'b1;
        setup_job(32'h300, 32'h400, 2);
        push_job(32'h300, 32'h400, 2);
        start_pulse();
        guard = 0;
        while (!master_write && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("midrst_reached_wr", 32'(master_write), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_write_drop", 32'(master_write), 32'd0);
        check_val("midrst_read_low", 32'(master_read), 32'd0);
        check_val("midrst_addr_zero", master_address, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_wr = 1'b0;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        csr_read(3'd0, v, w);
        check_val("midrst_status", v, 32'd0);
        check_val("midrst_idle_nowait", 32'(w), 32'd0);
        csr_read(3'd3, v, w);
        check_val("midrst_count_cleared", v, 32'd0);
        run_job(32'h800, 32'h900, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
